// File: rtl/ascii_to_dt_if.sv
// Character-in / decoded-value-out bundle for the ASCII decimal field decoder.
// The master drives characters; the slave (decoder) returns value and status pulses.
interface ascii_to_dt_if #(
   parameter int WIDTH = 8
);
   logic [7:0]       RX_DATA;
   logic             RX_VALID;
   logic [WIDTH-1:0] DT;
   logic             DT_VALID;
   logic             ERR;
   logic             BUSY;

   modport master (
      output RX_DATA,
      output RX_VALID,
      input  DT,
      input  DT_VALID,
      input  ERR,
      input  BUSY
   );

   modport slave (
      input  RX_DATA,
      input  RX_VALID,
      output DT,
      output DT_VALID,
      output ERR,
      output BUSY
   );
endinterface

// File: rtl/ascii_to_dt.sv
// ASCII decimal field decoder: accumulates digits up to a CR/LF terminator,
// publishing the value on DT or flagging ERR for malformed or out-of-range fields.
module ascii_to_dt #(
   parameter int WIDTH      = 8,
   parameter int MAX_DIGITS = 3,
   parameter int MAX_VALUE  = 255
) (
   input  logic          CLK,
   input  logic          RESET,
   ascii_to_dt_if.slave  bus
);

   localparam int AW = WIDTH + 4;
   localparam int CW = $clog2(MAX_DIGITS + 2);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ACCUM   = 2'd1;
   localparam logic [1:0] S_DISCARD = 2'd2;

   localparam logic [AW-1:0] MAXV_A = AW'(MAX_VALUE);
   localparam logic [CW-1:0] MAXD_C = CW'(MAX_DIGITS);

   logic [1:0]       state, state_n;
   logic [AW-1:0]    acc, acc_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] dt, dt_n;
   logic             dt_valid, dt_valid_n;
   logic             err, err_n;
   logic             busy;

   logic             is_digit;
   logic             is_term;
   logic             is_bs;
   logic [3:0]       dval;
   logic [AW-1:0]    acc_x10;
   logic [AW-1:0]    acc_div10;
   logic [CW-1:0]    cnt_inc;

   // Digit codes 0x30-0x39 carry their value in the low nibble.
   always_comb begin
      is_digit  = (bus.RX_DATA >= 8'h30) && (bus.RX_DATA <= 8'h39);
      is_term   = (bus.RX_DATA == 8'h0D) || (bus.RX_DATA == 8'h0A);
      is_bs     = (bus.RX_DATA == 8'h08);
      dval      = bus.RX_DATA[3:0];
      acc_x10   = (acc << 3) + (acc << 1) + AW'(dval);
      acc_div10 = acc / AW'(10);
      cnt_inc   = cnt + 1'b1;
   end

   always_comb begin
      state_n    = state;
      acc_n      = acc;
      cnt_n      = cnt;
      dt_n       = dt;
      dt_valid_n = 1'b0;
      err_n      = 1'b0;
      if (bus.RX_VALID) begin
         case (state)
            S_IDLE: begin
               if (is_digit) begin
                  acc_n   = AW'(dval);
                  cnt_n   = CW'(1);
                  state_n = S_ACCUM;
               end else if (!is_term && !is_bs) begin
                  state_n = S_DISCARD;
               end
            end
            S_ACCUM: begin
               if (is_digit) begin
                  // acc never exceeds MAX_VALUE here, so acc*10+9 fits in AW bits.
                  if ((cnt_inc > MAXD_C) || (acc_x10 > MAXV_A)) begin
                     state_n = S_DISCARD;
                  end else begin
                     acc_n = acc_x10;
                     cnt_n = cnt_inc;
                  end
               end else if (is_bs) begin
                  acc_n = acc_div10;
                  cnt_n = cnt - 1'b1;
                  if (cnt == CW'(1)) begin
                     state_n = S_IDLE;
                  end
               end else if (is_term) begin
                  dt_n       = acc[WIDTH-1:0];
                  dt_valid_n = 1'b1;
                  acc_n      = '0;
                  cnt_n      = '0;
                  state_n    = S_IDLE;
               end else begin
                  state_n = S_DISCARD;
               end
            end
            S_DISCARD: begin
               if (is_term) begin
                  err_n   = 1'b1;
                  acc_n   = '0;
                  cnt_n   = '0;
                  state_n = S_IDLE;
               end
            end
            default: begin
               acc_n   = '0;
               cnt_n   = '0;
               state_n = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= S_IDLE;
         acc      <= '0;
         cnt      <= '0;
         dt       <= '0;
         dt_valid <= 1'b0;
         err      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         acc      <= acc_n;
         cnt      <= cnt_n;
         dt       <= dt_n;
         dt_valid <= dt_valid_n;
         err      <= err_n;
         busy     <= (state_n != S_IDLE);
      end
   end

   assign bus.DT       = dt;
   assign bus.DT_VALID = dt_valid;
   assign bus.ERR      = err;
   assign bus.BUSY     = busy;

endmodule

// File: tb/tb_ascii_to_dt.sv
// Scoreboard bench for ascii_to_dt: a digit-list reference model predicts each
// character's response; a monitor compares the DUT outputs one cycle after each strobe.
module tb_ascii_to_dt;

   localparam int WIDTH = 8;
   localparam int MAXD  = 3;
   localparam int MAXV  = 255;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;
   always #5 CLK = ~CLK;

   ascii_to_dt_if #(.WIDTH(WIDTH)) bus ();

   ascii_to_dt #(
      .WIDTH(WIDTH),
      .MAX_DIGITS(MAXD),
      .MAX_VALUE(MAXV)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .bus(bus)
   );

   typedef struct {
      int due;
      bit v;
      bit e;
      bit b;
      int dt;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   // Reference model: the open field as a list of digit values.
   int fld[$];
   bit open = 1'b0;
   bit disc = 1'b0;
   int mdt  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int fval(input int q[$]);
      int v = 0;
      foreach (q[i]) v = v * 10 + q[i];
      return v;
   endfunction

   task automatic model(input logic [7:0] ch, input bit rst, output exp_t x);
      int tmp[$];
      x.due = cyc + 1;
      x.v   = 1'b0;
      x.e   = 1'b0;
      if (rst) begin
         open = 1'b0; disc = 1'b0; fld.delete(); mdt = 0;
      end else if (ch >= "0" && ch <= "9") begin
         if (!open) begin
            open = 1'b1; disc = 1'b0;
            fld.delete(); fld.push_back(int'(ch) - 48);
         end else if (!disc) begin
            tmp = fld;
            tmp.push_back(int'(ch) - 48);
            if (tmp.size() > MAXD || fval(tmp) > MAXV) disc = 1'b1;
            else fld = tmp;
         end
      end else if (ch == 8'h0D || ch == 8'h0A) begin
         if (open) begin
            if (disc) x.e = 1'b1;
            else begin
               mdt = fval(fld);
               x.v = 1'b1;
            end
            open = 1'b0; disc = 1'b0; fld.delete();
         end
      end else if (ch == 8'h08) begin
         if (open && !disc) begin
            void'(fld.pop_back());
            if (fld.size() == 0) open = 1'b0;
         end
      end else begin
         open = 1'b1; disc = 1'b1;
      end
      x.b  = open;
      x.dt = mdt;
   endtask

   task automatic drive(input logic [7:0] ch, input bit rst);
      exp_t x;
      @(negedge CLK);
      bus.RX_DATA  = ch;
      bus.RX_VALID = 1'b1;
      RESET        = rst;
      model(ch, rst, x);
      sbq.push_back(x);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         bus.RX_VALID = 1'b0;
         bus.RX_DATA  = 8'($urandom_range(0, 255));
         RESET        = 1'b0;
      end
   endtask

   // R=CR, L=LF, B=backspace; characters go out back-to-back.
   task automatic send(input string s);
      logic [7:0] c;
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         if (c == "R") c = 8'h0D;
         else if (c == "L") c = 8'h0A;
         else if (c == "B") c = 8'h08;
         drive(c, 1'b0);
      end
   endtask

   // Monitor
   initial begin
      exp_t x;
      forever begin
         @(posedge CLK);
         #1;
         if (sbq.size() > 0 && sbq[0].due == cyc) begin
            x = sbq.pop_front();
            check("dt_valid", 32'(bus.DT_VALID), 32'(x.v));
            check("err", 32'(bus.ERR), 32'(x.e));
            check("busy", 32'(bus.BUSY), 32'(x.b));
            check("dt", 32'(bus.DT), 32'(x.dt));
         end else if (bus.DT_VALID === 1'b1 || bus.ERR === 1'b1) begin
            check("unexpected_pulse", {30'd0, bus.DT_VALID, bus.ERR}, 32'd0);
         end
      end
   end

   initial begin
      logic [7:0] ch;
      int         r;
      bus.RX_VALID = 1'b0;
      bus.RX_DATA  = 8'h00;
      RESET        = 1'b1;
      repeat (3) @(negedge CLK);
      check("reset_dt", 32'(bus.DT), 32'd0);
      check("reset_dt_valid", 32'(bus.DT_VALID), 32'd0);
      check("reset_err", 32'(bus.ERR), 32'd0);
      check("reset_busy", 32'(bus.BUSY), 32'd0);
      idle(2);

      send("128R");
      idle(2);
      check("dir_128", 32'(bus.DT), 32'd128);
      send("256R");
      idle(2);
      check("dir_256_dt_kept", 32'(bus.DT), 32'd128);
      check("dir_256_busy", 32'(bus.BUSY), 32'd0);
      send("0042R");
      idle(1);
      send("7R");
      idle(2);
      check("dir_0042_then_7", 32'(bus.DT), 32'd7);
      send("12B5R");
      idle(2);
      check("dir_bs_15", 32'(bus.DT), 32'd15);
      send("9BBR");
      idle(2);
      check("dir_bs_empty_dt", 32'(bus.DT), 32'd15);
      check("dir_bs_empty_busy", 32'(bus.BUSY), 32'd0);
      send("3RL");
      idle(2);
      check("dir_crlf", 32'(bus.DT), 32'd3);
      send("12");
      drive("5", 1'b1);
      idle(1);
      check("dir_reset_dt", 32'(bus.DT), 32'd0);
      check("dir_reset_busy", 32'(bus.BUSY), 32'd0);
      send("7R");
      idle(2);
      check("dir_after_reset", 32'(bus.DT), 32'd7);

      for (int n = 0; n < 2000; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 55) ch = 8'(8'h30 + $urandom_range(0, 9));
         else if (r < 65) ch = 8'h0D;
         else if (r < 72) ch = 8'h0A;
         else if (r < 82) ch = 8'h08;
         else begin
            ch = 8'($urandom_range(0, 255));
            while ((ch >= 8'h30 && ch <= 8'h39) || ch == 8'h0D || ch == 8'h0A || ch == 8'h08)
               ch = 8'($urandom_range(0, 255));
         end
         drive(ch, $urandom_range(0, 199) == 0);
         idle(int'($urandom_range(0, 2)));
      end

      idle(4);
      check("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ascii_to_dt.md
ASCII_TO_DT -- requirements
Module: ascii_to_dt

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, the bit width of the decoded value DT.
REQ-002 The module SHALL have parameter MAX_DIGITS, default 3, the maximum number of decimal digits accepted per field.
REQ-003 The module SHALL have parameter MAX_VALUE, default 255, the largest accepted decoded value, with MAX_VALUE <= 2^WIDTH-1.
REQ-004 The module SHALL use one clock, CLK, and a synchronous active-high reset, RESET.
REQ-005 CLK  input  1  system clock; all state updates occur on the rising edge.
REQ-006 RESET  input  1  synchronous active-high reset.
REQ-007 RX_DATA  input  8  ASCII character; sampled only when RX_VALID=1.
REQ-008 RX_VALID  input  1  single-cycle strobe marking RX_DATA valid; no backpressure.
REQ-009 DT  output  WIDTH  last successfully decoded value; holds between updates.
REQ-010 DT_VALID  output  1  one-cycle pulse: DT has just been updated.
REQ-011 ERR  output  1  one-cycle pulse: the terminated field was rejected.
REQ-012 BUSY  output  1  high while a field is open (state ACCUM or DISCARD).

Function
REQ-013 The module SHALL implement three states: IDLE, ACCUM and DISCARD.
REQ-014 The module SHALL hold an accumulator ACC of width WIDTH+4 and a digit counter CNT.
REQ-015 The module SHALL act only on cycles with RX_VALID=1; on all other cycles, state, ACC, CNT and DT are unchanged.
REQ-016 Character classes SHALL be:
- digit: 0x30-0x39, with value d = RX_DATA-0x30;
- terminator: 0x0D or 0x0A;
- backspace: 0x08;
- other: every remaining code.
REQ-017 In IDLE, a digit SHALL set ACC=d and CNT=1, and enter ACCUM.
REQ-018 In IDLE, a terminator or backspace SHALL be ignored, so that CR LF pairs and empty lines produce no pulse.
REQ-019 In IDLE, an other character SHALL enter DISCARD.
REQ-020 In ACCUM, a digit SHALL set ACC=ACC*10+d and CNT=CNT+1.
REQ-021 In ACCUM, if CNT+1 > MAX_DIGITS or the new ACC > MAX_VALUE, the module SHALL enter DISCARD instead of REQ-020.
REQ-022 Leading zeros SHALL count toward MAX_DIGITS.
REQ-023 In ACCUM, a backspace SHALL set ACC=ACC/10 and CNT=CNT-1, returning to IDLE when CNT reaches 0.
REQ-024 In ACCUM, a terminator SHALL set DT=ACC[WIDTH-1:0], pulse DT_VALID, clear ACC and CNT, and return to IDLE.
REQ-025 In ACCUM, an other character SHALL enter DISCARD.
REQ-026 In DISCARD, digits, backspaces and other characters SHALL be ignored.
REQ-027 In DISCARD, a terminator SHALL pulse ERR, clear ACC and CNT, and return to IDLE, leaving DT unchanged.
REQ-028 Latency: DT_VALID or ERR SHALL be high in the cycle after the terminator's RX_VALID cycle, for exactly one cycle.
REQ-029 DT SHALL change in the same edge that raises DT_VALID.
REQ-030 DT_VALID and ERR SHALL never be high in the same cycle.
REQ-031 Back-to-back RX_VALID on consecutive cycles SHALL be accepted with no character lost.
REQ-032 BUSY SHALL be registered and SHALL reflect the state after each edge.

Reset
REQ-033 When RESET=1 at an edge, the module SHALL take state IDLE, ACC=0, CNT=0, DT=0, DT_VALID=0, ERR=0 and BUSY=0.
REQ-034 RESET SHALL take priority over RX_VALID in the same cycle; that character is dropped.
REQ-035 A reset in mid-field SHALL discard the partial field with no pulse.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- "128" CR -> DT=0x80 and DT_VALID for one cycle, one cycle after the CR strobe; ERR=0.
- "256" CR -> ERR pulse; DT keeps its previous value; BUSY falls after the CR.
- "0042" CR -> ERR pulse (4 digits > MAX_DIGITS); next "7" CR -> DT=7.
- "12" BS "5" CR -> DT=15; "9" BS BS CR -> no pulse; state IDLE.
- "3" CR LF sent on consecutive cycles -> exactly one DT_VALID (DT=3); LF ignored.
- "1" "2", then RESET, then "7" CR -> DT=0 after reset, then DT=7; no ERR.
